// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN streaming stages (frame transmitter, pool, conv).
// Contents:
//   PIX_W, CH             pixel width and channels per pixel
//   IMG_W_DEF, IMG_H_DEF  default feature-map geometry
//   stream_state_e        stream FSM state encoding (IDLE/STREAM/GAP/DRAIN)
//   pix_ch()              extracts one channel from a packed {ch7..ch0} pixel word
package cnn_stream_pkg;

    localparam int PIX_W     = 8;
    localparam int CH        = 8;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_DRAIN  = 2'd3
    } stream_state_e;

    // Channel c of a packed pixel word; channel 0 occupies the least significant byte.
    function automatic logic [PIX_W-1:0] pix_ch(input logic [CH*PIX_W-1:0] word, input int c);
        return word[c*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port frame RAM: one write port and one synchronous read port.
// Ports:
//   clk          rising-edge clock
//   we/waddr/wdata  write port (written at the next edge)
//   re/raddr        read request; rdata holds mem[raddr] from the edge after re
//   rdata        registered read data (not reset; qualified downstream)
module fmap_ram #(
    parameter int DEPTH = 784,
    parameter int AW    = 10,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [DW-1:0] rdata_r;

    // Storage write port; callers guarantee waddr < DEPTH when we is high
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Synchronous read port; data is held between reads
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fmap_stream_tx.sv
// Frame-buffered raster transmitter feeding a conv layer's 8-channel pixel input.
// A loader fills one IMG_W x IMG_H frame; start replays it in raster order.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  frame write port (accepted only while idle and in range)
//   wr_err                 1-cycle pulse after a dropped write
//   start                  begin replaying the stored frame (ignored unless idle)
//   stall                  hold off issuing further pixels while high
//   busy                   stream in progress (start accepted .. last pixel out)
//   done                   pulse on the last pixel's out_valid cycle
//   out_valid, out_data0..7  pixel stream; data forced to 0 when not valid
module fmap_stream_tx
    import cnn_stream_pkg::*;
#(
    parameter  int IMG_W   = IMG_W_DEF,
    parameter  int IMG_H   = IMG_H_DEF,
    parameter  int ROW_GAP = 0,
    localparam int DEPTH   = IMG_W * IMG_H,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    output logic          wr_err,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    output logic [7:0]    out_data0,
    output logic [7:0]    out_data1,
    output logic [7:0]    out_data2,
    output logic [7:0]    out_data3,
    output logic [7:0]    out_data4,
    output logic [7:0]    out_data5,
    output logic [7:0]    out_data6,
    output logic [7:0]    out_data7
);

    localparam int CW = $clog2(IMG_W) + 1;
    localparam int RW = $clog2(IMG_H) + 1;
    localparam int GW = $clog2(ROW_GAP + 1) + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((ROW_GAP > 0) ? (ROW_GAP - 1) : 0);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

    stream_state_e state_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [GW-1:0] gap_r;
    logic [AW-1:0] addr_r;
    logic          busy_r;
    logic          rd_vld_r;
    logic          rd_last_r;
    logic          out_valid_r;
    logic          done_r;
    logic          wr_err_r;
    logic [63:0]   out_data_r;

    logic          issue_s;
    logic          in_range_s;
    logic          ram_we_s;
    logic [63:0]   rd_data_s;

    // Read issue and write acceptance decisions
    always_comb begin
        issue_s    = 1'b0;
        in_range_s = 1'b0;
        ram_we_s   = 1'b0;
        if (state_r == ST_STREAM) begin
            issue_s = ~stall;
        end else begin
            issue_s = 1'b0;
        end
        in_range_s = ({1'b0, wr_addr} < DEPTH_C);
        if (wr_en && !busy_r && in_range_s) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    fmap_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (64)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (issue_s),
        .raddr (addr_r),
        .rdata (rd_data_s)
    );

    // Stream FSM: raster counters, incremental address and read-issue tagging.
    // DRAIN is held until the last pixel is on the outputs so that a start in
    // the done cycle is still ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            col_r     <= '0;
            row_r     <= '0;
            gap_r     <= '0;
            addr_r    <= '0;
            busy_r    <= 1'b0;
            rd_vld_r  <= 1'b0;
            rd_last_r <= 1'b0;
        end else begin
            rd_vld_r  <= 1'b0;
            rd_last_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_STREAM;
                        col_r   <= '0;
                        row_r   <= '0;
                        gap_r   <= '0;
                        addr_r  <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (!stall) begin
                        rd_vld_r <= 1'b1;
                        addr_r   <= addr_r + AW'(1);
                        if (col_r == COL_LAST) begin
                            col_r <= '0;
                            if (row_r == ROW_LAST) begin
                                state_r   <= ST_DRAIN;
                                rd_last_r <= 1'b1;
                            end else begin
                                row_r   <= row_r + RW'(1);
                                gap_r   <= '0;
                                state_r <= (ROW_GAP == 0) ? ST_STREAM : ST_GAP;
                            end
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_GAP: begin
                    if (!stall) begin
                        if (gap_r == GAP_LAST) begin
                            state_r <= ST_STREAM;
                        end else begin
                            gap_r <= gap_r + GW'(1);
                        end
                    end else begin
                        state_r <= ST_GAP;
                    end
                end
                ST_DRAIN: begin
                    if (done_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output register stage: pixel, done and write-error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            wr_err_r    <= 1'b0;
            out_data_r  <= 64'd0;
        end else begin
            out_valid_r <= rd_vld_r;
            done_r      <= rd_last_r;
            wr_err_r    <= wr_en & ~ram_we_s;
            out_data_r  <= rd_vld_r ? rd_data_s : 64'd0;
        end
    end

    assign wr_err    = wr_err_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign out_data0 = pix_ch(out_data_r, 0);
    assign out_data1 = pix_ch(out_data_r, 1);
    assign out_data2 = pix_ch(out_data_r, 2);
    assign out_data3 = pix_ch(out_data_r, 3);
    assign out_data4 = pix_ch(out_data_r, 4);
    assign out_data5 = pix_ch(out_data_r, 5);
    assign out_data6 = pix_ch(out_data_r, 6);
    assign out_data7 = pix_ch(out_data_r, 7);

endmodule
